// File: rtl/target_tx_gate.sv
// Gated 8N1 UART transmitter for the target link. Bytes are queued in a small FIFO,
// and a new frame may start only from IDLE while tx_release is high.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | line idle high; pops the FIFO head when released and non-empty
// S_START | start bit (low) for CLKS_PER_BIT cycles
// S_DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
// S_STOP  | stop bit (high) for CLKS_PER_BIT cycles
module target_tx_gate #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              tx_release,
    output logic              dout,
    output logic              busy,
    output logic [ADDR_W:0]   level,
    output logic              drop
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]  LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_drop;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_dout;

    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_bit_end;

    assign w_full    = (r_level == LEVEL_FULL);
    assign w_push    = in_valid && !w_full && !flush;
    // A flush empties the queue on the same edge, so it also suppresses a pop.
    assign w_pop     = (r_state == S_IDLE) && tx_release && (r_level != '0) && !flush;
    assign w_bit_end = (r_cnt == CNT_LAST);

    assign in_ready = !w_full;
    assign level    = r_level;
    assign drop     = r_drop;
    assign dout     = r_dout;
    assign busy     = (r_state != S_IDLE) || (r_level != '0);

    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_drop <= in_valid && w_full;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                end
                if (w_push && !w_pop) begin
                    r_level <= r_level + (ADDR_W + 1)'(1);
                end else if (w_pop && !w_push) begin
                    r_level <= r_level - (ADDR_W + 1)'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_dout    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_dout <= 1'b1;
                    r_cnt  <= '0;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_state <= S_START;
                        r_dout  <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_bit_idx <= 3'd0;
                        r_state   <= S_DATA;
                        r_dout    <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_dout  <= 1'b1;
                        end else begin
                            // Shift right so the next bit to send always sits at r_shift[1].
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_dout    <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_dout  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_target_tx_gate.sv
// Directed bench for target_tx_gate: pushed bytes go into a scoreboard queue and a
// line monitor decodes every frame on dout and pops/compares it.
module tb_target_tx_gate;

    localparam int CPB    = 4;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst_n;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic              tx_release;
    logic              dout;
    logic              busy;
    logic [ADDR_W:0]   level;
    logic              drop;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb[$];
    int         cyc         = 0;
    int         last_start  = -1;
    bit         spacing_en  = 1'b0;
    bit         allow_start = 1'b1;
    bit         m_active    = 1'b0;
    int         m_pos       = 0;
    logic [7:0] m_byte      = 8'd0;

    target_tx_gate #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH),
        .ADDR_W       (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .tx_release (tx_release),
        .dout       (dout),
        .busy       (busy),
        .level      (level),
        .drop       (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, input bit expect_sent);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (expect_sent) sb.push_back(b);
    endtask

    // Line monitor: bit centres are sampled on the falling edge, frames are decoded independently of the DUT.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n !== 1'b1) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (dout === 1'b0) begin
                m_active = 1'b1;
                m_pos    = 0;
                m_byte   = 8'd0;
                check("start_allowed", 32'(allow_start), 32'd1);
                if (spacing_en && last_start >= 0) check("start_spacing", cyc - last_start, 41);
                last_start = cyc;
            end
        end else begin
            m_pos = m_pos + 1;
            if (m_pos == CPB / 2) begin
                check("start_bit", 32'(dout), 32'd0);
            end else if (m_pos >= CPB + CPB / 2 && m_pos < 9 * CPB && (m_pos % CPB) == CPB / 2) begin
                m_byte[3'((m_pos - CPB) / CPB)] = dout;
            end else if (m_pos == 9 * CPB + CPB / 2) begin
                check("stop_bit", 32'(dout), 32'd1);
            end
            if (m_pos == 10 * CPB - 1) begin
                m_active = 1'b0;
                check("frame_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) check("frame_byte", 32'(m_byte), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        in_data    = 8'd0;
        in_valid   = 1'b0;
        flush      = 1'b0;
        tx_release = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", 32'(dout), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_drop", 32'(drop), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single frame 0xA5: start 1 cycle after the qualifying cycle, 40 cycles total.
        push(8'hA5, 1'b1);
        check("t1_level_after_push", 32'(level), 32'd1);
        check("t1_dout_before_pop", 32'(dout), 32'd1);
        @(posedge clk); #1;
        check("t1_start_low", 32'(dout), 32'd0);
        check("t1_level_after_pop", 32'(level), 32'd0);
        check("t1_busy_in_frame", 32'(busy), 32'd1);
        repeat (39) @(posedge clk);
        #1;
        check("t1_busy_last_stop", 32'(busy), 32'd1);
        check("t1_dout_stop", 32'(dout), 32'd1);
        @(posedge clk); #1;
        check("t1_busy_fell", 32'(busy), 32'd0);
        check("t1_sb_empty", 32'(sb.size()), 32'd0);

        // Hold then release five bytes; starts must be 41 cycles apart.
        tx_release  = 1'b0;
        allow_start = 1'b0;
        for (int i = 1; i <= 5; i++) push(8'(i), 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check("t2_level_held", 32'(level), 32'd5);
        check("t2_dout_idle", 32'(dout), 32'd1);
        check("t2_busy_queued", 32'(busy), 32'd1);
        last_start  = -1;
        spacing_en  = 1'b1;
        allow_start = 1'b1;
        tx_release  = 1'b1;
        @(posedge clk); #1;
        check("t2_level_pop0", 32'(level), 32'd4);
        check("t2_start0", 32'(dout), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            repeat (41) @(posedge clk);
            #1;
            check("t2_level_pop", 32'(level), 32'(4 - k));
            check("t2_start", 32'(dout), 32'd0);
        end
        repeat (40) @(posedge clk);
        #1;
        check("t2_busy_done", 32'(busy), 32'd0);
        check("t2_sb_empty", 32'(sb.size()), 32'd0);
        spacing_en = 1'b0;

        // Fill to DEPTH, then one overflow push.
        tx_release  = 1'b0;
        allow_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i), 1'b1);
        check("t3_in_ready_full", 32'(in_ready), 32'd0);
        check("t3_level_full", 32'(level), 32'd16);
        push(8'hEE, 1'b0);
        check("t3_drop_pulse", 32'(drop), 32'd1);
        check("t3_level_after_drop", 32'(level), 32'd16);
        @(posedge clk); #1;
        check("t3_drop_one_cycle", 32'(drop), 32'd0);
        allow_start = 1'b1;
        tx_release  = 1'b1;
        repeat (DEPTH * 41 + 5) @(posedge clk);
        #1;
        check("t3_busy_drained", 32'(busy), 32'd0);
        check("t3_sb_empty", 32'(sb.size()), 32'd0);

        // Drop tx_release during bit 2 of 0x3C: frame completes, nothing further starts.
        tx_release  = 1'b0;
        allow_start = 1'b0;
        push(8'h3C, 1'b1);
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        allow_start = 1'b1;
        tx_release  = 1'b1;
        @(posedge clk); #1;
        check("t4_start", 32'(dout), 32'd0);
        check("t4_level_pop", 32'(level), 32'd2);
        repeat (13) @(posedge clk);
        #1;
        tx_release  = 1'b0;
        allow_start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("t4_level_held", 32'(level), 32'd2);
        check("t4_dout_idle", 32'(dout), 32'd1);
        check("t4_busy_held", 32'(busy), 32'd1);
        check("t4_sb_left", 32'(sb.size()), 32'd2);
        allow_start = 1'b1;
        tx_release  = 1'b1;
        repeat (2 * 41 + 5) @(posedge clk);
        #1;
        check("t4_sb_empty", 32'(sb.size()), 32'd0);
        check("t4_busy_done", 32'(busy), 32'd0);

        // Flush with a simultaneous push during the DATA state of 0x7E.
        tx_release  = 1'b0;
        allow_start = 1'b0;
        push(8'h7E, 1'b1);
        for (int i = 1; i <= 4; i++) push(8'(8'hA0 + i), 1'b0);
        check("t5_level_queued", 32'(level), 32'd5);
        allow_start = 1'b1;
        tx_release  = 1'b1;
        @(posedge clk); #1;
        check("t5_level_pop", 32'(level), 32'd4);
        repeat (9) @(posedge clk);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t5_level_flushed", 32'(level), 32'd0);
        check("t5_in_ready", 32'(in_ready), 32'd1);
        check("t5_busy_frame", 32'(busy), 32'd1);
        repeat (35) @(posedge clk);
        #1;
        check("t5_busy_done", 32'(busy), 32'd0);
        check("t5_sb_empty", 32'(sb.size()), 32'd0);

        // Reset in the middle of a frame.
        push(8'h55, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        check("t6_mid_frame_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t6_rst_dout", 32'(dout), 32'd1);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_level", 32'(level), 32'd0);
        rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("t6_idle_after_rst", 32'(dout), 32'd1);
        check("t6_busy_after_rst", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
